// File: rtl/contention_ctl.sv
// rtl/contention_ctl.sv - video raster timing, CPU clock enable and memory contention control
module contention_ctl #(
  parameter int HCOUNT   = 448,
  parameter int VCOUNT   = 312,
  parameter int INT_LINE = 248,
  parameter int INT_LEN  = 64
) (
  input  logic       clock70,
  input  logic       reset,
  input  logic       contend_req,
  input  logic       wait_n,
  output logic       ce_cpu,
  output logic       stall,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic       fetch,
  output logic       int_n,
  output logic       frame
);

  localparam logic [8:0] H_LAST = 9'(HCOUNT - 1);
  localparam logic [8:0] V_LAST = 9'(VCOUNT - 1);
  localparam logic [8:0] I_LINE = 9'(INT_LINE);
  // Remaining-cycle counter only ever holds INT_LEN-1 down to 0
  localparam int ICW = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
  localparam logic [ICW-1:0] I_LAST = ICW'(INT_LEN - 1);

  logic [8:0]     hc_q, hc_d;
  logic [8:0]     vc_q, vc_d;
  logic [ICW-1:0] int_cnt_q, int_cnt_d;
  logic           int_n_q, int_n_d;
  logic           frame_q, frame_d;

  logic h_wrap;
  logic v_wrap;
  logic int_start;
  logic contend_hit;

  assign h_wrap    = (hc_q == H_LAST);
  assign v_wrap    = (vc_q == V_LAST);
  assign int_start = (vc_q == I_LINE) && (hc_q == 9'd0);

  // Raster position: hc steps every clock, vc steps when hc wraps; both wrap together at frame end
  always_comb begin
    hc_d = h_wrap ? 9'd0 : hc_q + 9'd1;
    vc_d = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? 9'd0 : vc_q + 9'd1;
    end
  end

  // Interrupt window: low for INT_LEN cycles, beginning the cycle after hc=0 on the interrupt line
  always_comb begin
    int_cnt_d = int_cnt_q;
    int_n_d   = 1'b1;
    if (int_start) begin
      int_cnt_d = I_LAST;
      int_n_d   = 1'b0;
    end else if (int_cnt_q != '0) begin
      int_cnt_d = int_cnt_q - 1'b1;
      int_n_d   = 1'b0;
    end
  end

  // Frame marker: registered so it is visible while the raster sits at hc=0, vc=0
  always_comb begin
    frame_d = h_wrap && v_wrap;
  end

  // State registers; reset also aborts any interrupt in progress
  always_ff @(posedge clock70 or negedge reset) begin
    if (!reset) begin
      hc_q      <= 9'd0;
      vc_q      <= 9'd0;
      int_cnt_q <= '0;
      int_n_q   <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      int_cnt_q <= int_cnt_d;
      int_n_q   <= int_n_d;
      frame_q   <= frame_d;
    end
  end

  // Fetch window: first 6 T-states of each 8 T-state group inside the 256x192 display area
  always_comb begin
    fetch = (vc_q < 9'd192) && (hc_q < 9'd256) && (hc_q[3:0] < 4'd12);
  end

  // CPU enable on odd hc only; a contended slot is simply dropped, never queued
  always_comb begin
    contend_hit = contend_req && fetch;
    ce_cpu      = reset && hc_q[0] && wait_n && !contend_hit;
    stall       = reset && hc_q[0] && contend_hit;
  end

  assign hc    = hc_q;
  assign vc    = vc_q;
  assign int_n = int_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_contention_ctl.sv
// tb/tb_contention_ctl.sv - directed self-checking bench for contention_ctl
module tb_contention_ctl;

  localparam int H            = 64;
  localparam int V            = 202;
  localparam int IL           = 20;
  localparam int ILEN         = 64;
  localparam int FRAME        = 12928;
  localparam int LINE_PULSES  = 32;
  localparam int FRAME_PULSES = 6464;

  logic       clk;
  logic       reset;
  logic       contend_req;
  logic       wait_n;
  logic       ce_cpu;
  logic       stall;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       fetch;
  logic       int_n;
  logic       frame;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int ce_cnt   = 0;
  int low_cnt  = 0;

  contention_ctl #(
    .HCOUNT  (H),
    .VCOUNT  (V),
    .INT_LINE(IL),
    .INT_LEN (ILEN)
  ) dut (
    .clock70    (clk),
    .reset      (reset),
    .contend_req(contend_req),
    .wait_n     (wait_n),
    .ce_cpu     (ce_cpu),
    .stall      (stall),
    .hc         (hc),
    .vc         (vc),
    .fetch      (fetch),
    .int_n      (int_n),
    .frame      (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running tallies of clock edges, CPU enables and interrupt-low cycles
  always @(posedge clk) begin
    edge_cnt++;
    if (ce_cpu === 1'b1) ce_cnt++;
    if (int_n === 1'b0) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int v, input int h, input string tag);
    int n;
    n = 0;
    while (!(vc == 9'(v) && hc == 9'(h)) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach"}, {14'd0, vc, hc}, 32'((v << 9) | h));
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (frame !== 1'b1 && n < FRAME + 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(frame), 32'd1);
  endtask

  initial begin
    logic [15:0] exp_cont_ce;
    logic [15:0] exp_cont_stall;
    logic [15:0] exp_wc_ce;
    logic [15:0] exp_wc_stall;
    int rel_edge;
    int ce0;
    int low0;

    exp_cont_ce    = 16'b1010_0000_0000_0000;
    exp_cont_stall = 16'b0000_1010_1010_1010;
    exp_wc_ce      = 16'b1000_0000_0000_0000;
    exp_wc_stall   = 16'b0000_1010_1010_0000;

    reset       = 1'b0;
    contend_req = 1'b1;
    wait_n      = 1'b1;

    // Reset state with contention requested
    repeat (3) @(negedge clk);
    chk("rst_hc", 32'(hc), 32'd0);
    chk("rst_vc", 32'(vc), 32'd0);
    chk("rst_int_n", 32'(int_n), 32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_ce", 32'(ce_cpu), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Release reset with contend_req held from hc=0 on line 0
    reset    = 1'b1;
    rel_edge = edge_cnt;
    low0     = low_cnt;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("cont_hc", 32'(hc), 32'(i));
      chk("cont_ce", 32'(ce_cpu), 32'(exp_cont_ce[i]));
      chk("cont_stall", 32'(stall), 32'(exp_cont_stall[i]));
      chk("cont_fetch", 32'(fetch), (i < 12) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    contend_req = 1'b0;

    // Free-running enable count over one full line
    wait_pos(1, 0, "line1");
    ce0 = ce_cnt;
    wait_pos(2, 0, "line2");
    chk("line_pulses", 32'(ce_cnt - ce0), 32'(LINE_PULSES));

    // Wait plus contention, wait released at hc=14
    wait_pos(10, 5, "wc");
    contend_req = 1'b1;
    wait_n      = 1'b0;
    for (int h = 5; h <= 15; h++) begin
      if (h == 14) wait_n = 1'b1;
      #1;
      chk("wc_ce", 32'(ce_cpu), 32'(exp_wc_ce[h]));
      chk("wc_stall", 32'(stall), 32'(exp_wc_stall[h]));
      @(negedge clk);
    end
    contend_req = 1'b0;
    wait_n      = 1'b1;

    // Interrupt window on the interrupt line
    wait_pos(IL, 0, "int");
    chk("int_pre", 32'(int_n), 32'd1);
    for (int i = 0; i < ILEN; i++) begin
      @(negedge clk);
      chk("int_low", 32'(int_n), 32'd0);
    end
    @(negedge clk);
    chk("int_end", 32'(int_n), 32'd1);
    chk("int_end_pos", {14'd0, vc, hc}, 32'(((IL + 1) << 9) | 1));

    // Border line with contend_req held: free-run behaviour
    wait_pos(200, 0, "brd");
    contend_req = 1'b1;
    for (int h = 0; h < H; h++) begin
      #1;
      chk("brd_ce", 32'(ce_cpu), 32'(h & 1));
      chk("brd_stall", 32'(stall), 32'd0);
      chk("brd_fetch", 32'(fetch), 32'd0);
      @(negedge clk);
    end
    contend_req = 1'b0;

    // First frame pulse after release
    wait_frame("f1");
    chk("f1_period", 32'(edge_cnt - rel_edge), 32'(FRAME));
    chk("f1_pos", {14'd0, vc, hc}, 32'd0);
    chk("f1_int_lows", 32'(low_cnt - low0), 32'(ILEN));
    rel_edge = edge_cnt;
    ce0      = ce_cnt;
    low0     = low_cnt;
    @(negedge clk);
    chk("f1_width", 32'(frame), 32'd0);

    // Second frame, fully free-running
    wait_frame("f2");
    chk("f2_period", 32'(edge_cnt - rel_edge), 32'(FRAME));
    chk("f2_pulses", 32'(ce_cnt - ce0), 32'(FRAME_PULSES));
    chk("f2_int_lows", 32'(low_cnt - low0), 32'(ILEN));

    // Reset in the middle of the interrupt
    wait_pos(IL, 20, "mr");
    chk("mr_int_pre", 32'(int_n), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_int_n", 32'(int_n), 32'd1);
    chk("mr_hc", 32'(hc), 32'd0);
    chk("mr_vc", 32'(vc), 32'd0);
    chk("mr_frame", 32'(frame), 32'd0);
    @(negedge clk);
    chk("mr_hold_hc", 32'(hc), 32'd0);
    reset    = 1'b1;
    rel_edge = edge_cnt;
    low0     = low_cnt;
    wait_frame("mr");
    chk("mr_period", 32'(edge_cnt - rel_edge), 32'(FRAME));
    chk("mr_pos", {14'd0, vc, hc}, 32'd0);
    chk("mr_int_lows", 32'(low_cnt - low0), 32'(ILEN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
